// File: rtl/univ_shift_reg.sv
// Universal shift/count register. It can load, shift, rotate, increment and
// decrement. Shifts and rotates by more than one bit run over several cycles
// under a start/busy/done handshake.
module univ_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic [CNT_W-1:0] amt_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             zero_o,
  output logic             carry_o
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_INC  = 3'd6;
  localparam logic [2:0] MODE_DEC  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dout_q;
  logic             carry_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       mode_q;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] dout_d;
  logic             carry_d;
  logic             is_shift_mode;

  // Modes 2..5 are the shift/rotate family, which honours the amount input.
  assign is_shift_mode = (mode_i == MODE_SHL) || (mode_i == MODE_SHR) ||
                         (mode_i == MODE_ROL) || (mode_i == MODE_ROR);

  // One-step datapath: while idle it uses the incoming mode, while shifting
  // it uses the mode latched at accept.
  always_comb begin
    step_mode = (state_q == ST_IDLE) ? mode_i : mode_q;
    dout_d    = dout_q;
    carry_d   = carry_q;
    case (step_mode)
      MODE_HOLD: begin
        dout_d  = dout_q;
        carry_d = carry_q;
      end
      MODE_LOAD: begin
        dout_d  = din_i;
        carry_d = 1'b0;
      end
      MODE_SHL: begin
        dout_d  = {dout_q[WIDTH-2:0], sin_i};
        carry_d = dout_q[WIDTH-1];
      end
      MODE_SHR: begin
        dout_d  = {sin_i, dout_q[WIDTH-1:1]};
        carry_d = dout_q[0];
      end
      MODE_ROL: begin
        dout_d  = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
        carry_d = dout_q[WIDTH-1];
      end
      MODE_ROR: begin
        dout_d  = {dout_q[0], dout_q[WIDTH-1:1]};
        carry_d = dout_q[0];
      end
      MODE_INC: begin
        dout_d  = dout_q + WIDTH'(1);
        carry_d = &dout_q;
      end
      MODE_DEC: begin
        dout_d  = dout_q - WIDTH'(1);
        carry_d = ~|dout_q;
      end
      default: begin
        dout_d  = dout_q;
        carry_d = carry_q;
      end
    endcase
  end

  // Control FSM and registered datapath state. Reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dout_q  <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            mode_q <= mode_i;
            if (is_shift_mode && (amt_i == '0)) begin
              // A zero-length shift is a no-op that still completes.
              done_q <= 1'b1;
            end else begin
              dout_q  <= dout_d;
              carry_q <= carry_d;
              if (is_shift_mode && (amt_i > CNT_W'(1))) begin
                state_q <= ST_SHIFT;
                cnt_q   <= amt_i - CNT_W'(1);
              end else begin
                done_q <= 1'b1;
              end
            end
          end
        end
        ST_SHIFT: begin
          dout_q  <= dout_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign dout_o  = dout_q;
  assign busy_o  = (state_q == ST_SHIFT);
  assign done_o  = done_q;
  assign carry_o = carry_q;
  assign zero_o  = (dout_q == '0);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, CNT_W=4). It applies a
// per-cycle vector table and then a hand-written sequence that resets the
// register in the middle of a shift.
module tb_univ_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] M_HOLD = 3'd0;
  localparam logic [2:0] M_LOAD = 3'd1;
  localparam logic [2:0] M_SHL  = 3'd2;
  localparam logic [2:0] M_SHR  = 3'd3;
  localparam logic [2:0] M_ROL  = 3'd4;
  localparam logic [2:0] M_ROR  = 3'd5;
  localparam logic [2:0] M_INC  = 3'd6;
  localparam logic [2:0] M_DEC  = 3'd7;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic [2:0]       mode_i;
  logic [WIDTH-1:0] din_i;
  logic [CNT_W-1:0] amt_i;
  logic             sin_i;
  logic [WIDTH-1:0] dout_o;
  logic             busy_o;
  logic             done_o;
  logic             zero_o;
  logic             carry_o;

  int total;
  int bad;

  typedef struct {
    logic             rst;
    logic             start;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic [CNT_W-1:0] amt;
    logic             sin;
    logic [WIDTH-1:0] e_dout;
    logic             e_busy;
    logic             e_done;
    logic             e_carry;
  } vec_t;

  vec_t vecs[$];

  univ_shift_reg #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_i),
    .mode_i (mode_i),
    .din_i  (din_i),
    .amt_i  (amt_i),
    .sin_i  (sin_i),
    .dout_o (dout_o),
    .busy_o (busy_o),
    .done_o (done_o),
    .zero_o (zero_o),
    .carry_o(carry_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic s, input logic [2:0] m,
                     input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] a,
                     input logic si, input logic [WIDTH-1:0] ed,
                     input logic eb, input logic edn, input logic ec);
    vec_t v;
    v.rst = r; v.start = s; v.mode = m; v.din = d; v.amt = a; v.sin = si;
    v.e_dout = ed; v.e_busy = eb; v.e_done = edn; v.e_carry = ec;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic s, input logic [2:0] m,
                       input logic [WIDTH-1:0] d, input logic [CNT_W-1:0] a,
                       input logic si);
    rst = r; start_i = s; mode_i = m; din_i = d; amt_i = a; sin_i = si;
  endtask

  task automatic check_all(input string tag, input logic [WIDTH-1:0] ed,
                           input logic eb, input logic edn, input logic ec);
    logic ez;
    ez = (ed == '0);
    total++;
    if (dout_o !== ed) begin
      bad++;
      $display("FAIL %s dout: got %h want %h", tag, dout_o, ed);
    end
    total++;
    if (busy_o !== eb) begin
      bad++;
      $display("FAIL %s busy: got %b want %b", tag, busy_o, eb);
    end
    total++;
    if (done_o !== edn) begin
      bad++;
      $display("FAIL %s done: got %b want %b", tag, done_o, edn);
    end
    total++;
    if (carry_o !== ec) begin
      bad++;
      $display("FAIL %s carry: got %b want %b", tag, carry_o, ec);
    end
    total++;
    if (zero_o !== ez) begin
      bad++;
      $display("FAIL %s zero: got %b want %b", tag, zero_o, ez);
    end
  endtask

  // Drive one cycle of inputs, clock, then sample just after the edge.
  task automatic step(input string tag, input logic r, input logic s,
                      input logic [2:0] m, input logic [WIDTH-1:0] d,
                      input logic [CNT_W-1:0] a, input logic si,
                      input logic [WIDTH-1:0] ed, input logic eb,
                      input logic edn, input logic ec);
    drive(r, s, m, d, a, si);
    @(posedge clk);
    #1;
    check_all(tag, ed, eb, edn, ec);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    drive(1'b1, 1'b1, M_LOAD, 8'hFF, 4'd0, 1'b0);

    //   rst  st  mode    din    amt  sin  dout   busy done carry
    add(1'b1, 1'b1, M_LOAD, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, M_LOAD, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, M_LOAD, 8'hA5, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b0);
    // SHL by 3 with sin=1
    add(1'b0, 1'b1, M_SHL,  8'h00, 4'd3, 1'b1, 8'h4B, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h97, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h2F, 1'b0, 1'b1, 1'b1);
    // counter wrap in both directions
    add(1'b0, 1'b1, M_LOAD, 8'hFF, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, M_INC,  8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, M_DEC,  8'h00, 4'd0, 1'b0, 8'hFF, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, M_DEC,  8'h00, 4'd0, 1'b0, 8'hFE, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0);
    // full rotate right by 8, with a LOAD start ignored while busy
    add(1'b0, 1'b1, M_LOAD, 8'h3C, 4'd0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, M_ROR,  8'h00, 4'd8, 1'b1, 8'h1E, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b1, M_LOAD, 8'h00, 4'd0, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h87, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'hE1, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h78, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    // zero-length shift is a no-op that completes in one cycle
    add(1'b0, 1'b1, M_SHL,  8'h00, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    // ROL by 1 is single-cycle; carry is then held by no-op and HOLD
    add(1'b0, 1'b1, M_LOAD, 8'h81, 4'd0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b1, M_ROL,  8'h00, 4'd1, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, M_SHL,  8'h00, 4'd0, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1);
    add(1'b0, 1'b1, M_HOLD, 8'h55, 4'd5, 1'b0, 8'h03, 1'b0, 1'b1, 1'b1);
    // SHR by 2; sin is sampled on each step edge
    add(1'b0, 1'b1, M_SHR,  8'h00, 4'd2, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1);
    add(1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      step(tag, vecs[i].rst, vecs[i].start, vecs[i].mode, vecs[i].din,
           vecs[i].amt, vecs[i].sin, vecs[i].e_dout, vecs[i].e_busy,
           vecs[i].e_done, vecs[i].e_carry);
    end

    // Reset mid-shift: SHR by 10 from 0x80, rst asserted after four steps.
    step("rm_s1", 1'b0, 1'b1, M_SHR, 8'h00, 4'd10, 1'b0, 8'h40, 1'b1, 1'b0, 1'b0);
    step("rm_s2", 1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0);
    step("rm_s3", 1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0, 8'h10, 1'b1, 1'b0, 1'b0);
    step("rm_s4", 1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0, 8'h08, 1'b1, 1'b0, 1'b0);
    step("rm_rst", 1'b1, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      step($sformatf("rm_quiet%0d", k), 1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0,
           8'h00, 1'b0, 1'b0, 1'b0);
    end
    step("rm_load", 1'b0, 1'b1, M_LOAD, 8'h5A, 4'd0, 1'b0, 8'h5A, 1'b0, 1'b1, 1'b0);
    step("rm_after", 1'b0, 1'b0, M_HOLD, 8'h00, 4'd0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift/count register. It succeeds the fixed 4-bit clearable data register, and adds the following:
- configurable width;
- eight operation modes;
- multi-cycle shift/rotate by a programmable amount, controlled by a start/busy/done handshake;
- status flags.

It sits in the lab datapath wherever a working register has to load, shift, rotate, or count under control-FSM command.

Parameters:
WIDTH, 8, data register width in bits (>=2)
CNT_W, 4, width of shift-amount input; max amount 2**CNT_W-1

Ports:
clk    input   1        system clock, all state updates on rising edge
rst    input   1        synchronous, active-high reset
start  input   1        command strobe; accepted only when busy=0
mode   input   3        operation select, sampled at accept edge
din    input   WIDTH    parallel load data, sampled at accept edge
amt    input   CNT_W    shift/rotate count, sampled at accept edge
sin    input   1        serial-in bit, sampled on every shift edge
dout   output  WIDTH    register contents
busy   output  1        multi-cycle shift in progress
done   output  1        one-cycle pulse: operation completed
zero   output  1        combinational, (dout == 0)
carry  output  1        registered status bit (see below)

Behaviour:
- Reset (clk and rst are the only ports named by convention; rst is synchronous, active-high):
  - rst=1 at a rising edge forces dout=0, busy=0, done=0, carry=0 and the internal count to 0.
  - rst overrides start and any in-progress shift.
  - zero=1 after reset.
- States:
  - IDLE (busy=0) and SHIFT (busy=1).
  - Accept edge = rising edge with start=1, busy=0, rst=0.
  - mode, amt and din are latched at the accept edge. Later changes to them are ignored until the next accept.
- Mode encoding:
  - 0 HOLD
  - 1 LOAD
  - 2 SHL (sin into LSB)
  - 3 SHR (sin into MSB)
  - 4 ROL
  - 5 ROR
  - 6 INC
  - 7 DEC
- Single-cycle modes (HOLD, LOAD, INC, DEC):
  - dout is updated at the accept edge and done=1 for the following cycle. busy stays 0.
  - HOLD: dout and carry are unchanged.
  - LOAD: dout=din, carry=0.
  - INC: dout=dout+1 mod 2**WIDTH; carry=1 iff old dout was all ones.
  - DEC: dout=dout-1 mod 2**WIDTH; carry=1 iff old dout was 0 (borrow).
- Shift/rotate modes (2-5), amt=N:
  - N=0: no-op. dout and carry are unchanged, done pulses next cycle, busy stays 0.
  - N>=1: one single-bit step per edge for exactly N edges. The first step happens at the accept edge.
  - N=1: behaves like a single-cycle mode.
  - N>1: busy=1 from after the accept edge through the cycle before the final step. The FSM enters SHIFT and returns to IDLE at the Nth step edge. busy=0 and done=1 in the cycle after that edge.
  - Latency, accept edge to done high: N cycles (N>=1); 1 cycle for single-cycle modes and N=0.
- carry after shift/rotate steps:
  - SHL/ROL: carry = bit shifted out of the MSB.
  - SHR/ROR: carry = bit shifted out of the LSB.
  - carry updates on every step; the value after the last step is the one held.
  - ROL/ROR: the outgoing bit re-enters at the opposite end; sin is ignored.
- Start handling:
  - start while busy=1 is ignored; no queueing.
  - start in the done cycle (busy=0) is accepted normally, which allows back-to-back operations.
- Status outputs:
  - done is high exactly one cycle per accepted command.
  - carry holds its value across IDLE until the next operation that updates it.
- Reset mid-shift: the shift aborts immediately; no done pulse is generated for the aborted command.

Test Plan:
- Reset: hold rst=1 for 2 edges with start=1, mode=LOAD, din=0xFF -> dout=0x00, zero=1, busy=0, done=0, carry=0.
- Load: start, mode=LOAD, din=0xA5 -> dout=0xA5 after 1 edge, done high 1 cycle, busy never 1, zero=0.
- Multi-cycle shift: from 0xA5, start, mode=SHL, amt=3, sin=1 held.
  - After each edge, dout goes 0x4B (carry=1), 0x97 (carry=0), 0x2F (carry=1).
  - busy=1 for 2 cycles; done pulses once, 3 cycles after accept.
- Counter wrap: LOAD 0xFF, then INC -> dout=0x00, carry=1, zero=1. Then DEC -> dout=0xFF, carry=1. Then DEC -> 0xFE, carry=0.
- Rotate identity and ignored start: LOAD 0x3C, then ROR amt=8.
  - Pulse start with mode=LOAD, din=0x00 while busy -> ignored.
  - Final dout=0x3C, carry=0, one done pulse after 8 cycles.
  - amt=0 on SHL -> dout unchanged, done after 1 cycle.
- Reset mid-operation: start SHR amt=10 from 0x80 and assert rst after 4 steps -> next cycle dout=0, busy=0. No done pulse follows; a new LOAD is accepted on the next start.
